// File: rtl/mem_model_pkg.sv
// Shared types and constants for the memory latency responder.
//   mm_state_t   : per-channel responder FSM states
//   mm_op_t      : operation latched at request acceptance
//   CNT_BITS     : width of the latency down-counter (LATENCY up to 15)
//   latency_load : value loaded into the counter when a request is accepted
package mem_model_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, RESP, DONE} mm_state_t;
    typedef enum logic {OP_READ, OP_WRITE} mm_op_t;

    localparam int CNT_BITS = 4;

    // BUSY counts down to zero before RESP, so the load value is LATENCY-1.
    function automatic logic [CNT_BITS-1:0] latency_load(input int latency);
        return CNT_BITS'(latency - 1);
    endfunction

endpackage

// File: rtl/mem_model_channel.sv
// One responder channel: accepts a read or write request, waits LATENCY
// cycles, then issues a single-cycle ready pulse.
// Ports:
//   clk, reset                     clock, asynchronous active-low reset
//   read_valid/read_address        read request in
//   read_ready/read_data           registered read completion pulse and word
//   write_valid/write_address/_data write request in
//   write_ready                    registered write completion pulse
//   mem_addr / mem_rdata           lookup of the latched address in the shared array
//   commit/commit_addr/commit_data write strobe toward the shared array (RESP cycle)
module mem_model_channel
    import mem_model_pkg::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 16,
    parameter int LATENCY   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 read_valid,
    input  logic [ADDR_BITS-1:0] read_address,
    output logic                 read_ready,
    output logic [DATA_BITS-1:0] read_data,
    input  logic                 write_valid,
    input  logic [ADDR_BITS-1:0] write_address,
    input  logic [DATA_BITS-1:0] write_data,
    output logic                 write_ready,
    output logic [ADDR_BITS-1:0] mem_addr,
    input  logic [DATA_BITS-1:0] mem_rdata,
    output logic                 commit,
    output logic [ADDR_BITS-1:0] commit_addr,
    output logic [DATA_BITS-1:0] commit_data
);

    mm_state_t             state_reg;
    mm_op_t                op_reg;
    logic [ADDR_BITS-1:0]  addr_reg;
    logic [DATA_BITS-1:0]  data_reg;
    logic [CNT_BITS-1:0]   cnt_reg;
    logic                  read_ready_reg;
    logic                  write_ready_reg;
    logic [DATA_BITS-1:0]  read_data_reg;
    logic                  op_valid;

    // Valid of the operation currently being served; DONE waits for it to fall.
    assign op_valid = (op_reg == OP_READ) ? read_valid : write_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= IDLE;
            op_reg          <= OP_READ;
            addr_reg        <= '0;
            data_reg        <= '0;
            cnt_reg         <= '0;
            read_ready_reg  <= 1'b0;
            write_ready_reg <= 1'b0;
            read_data_reg   <= '0;
        end else begin
            read_ready_reg  <= 1'b0;
            write_ready_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // Read has priority; a pending write is picked up on a later pass.
                    if (read_valid) begin
                        op_reg    <= OP_READ;
                        addr_reg  <= read_address;
                        cnt_reg   <= latency_load(LATENCY);
                        state_reg <= BUSY;
                    end else if (write_valid) begin
                        op_reg    <= OP_WRITE;
                        addr_reg  <= write_address;
                        data_reg  <= write_data;
                        cnt_reg   <= latency_load(LATENCY);
                        state_reg <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_reg == '0) begin
                        // Ready is registered, so it is raised on the edge entering RESP.
                        // Read data is captured here too: a write committing at the end
                        // of this cycle's RESP elsewhere is not yet visible (old word).
                        state_reg <= RESP;
                        if (op_reg == OP_READ) begin
                            read_ready_reg <= 1'b1;
                            read_data_reg  <= mem_rdata;
                        end else begin
                            write_ready_reg <= 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - CNT_BITS'(1);
                    end
                end
                RESP: begin
                    state_reg <= DONE;
                end
                DONE: begin
                    if (!op_valid) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign read_ready  = read_ready_reg;
    assign write_ready = write_ready_reg;
    assign read_data   = read_data_reg;
    assign mem_addr    = addr_reg;

    // Write lands in the array on the edge that ends RESP; a reset during BUSY
    // never reaches RESP, so that write is dropped.
    assign commit      = (state_reg == RESP) && (op_reg == OP_WRITE);
    assign commit_addr = addr_reg;
    assign commit_data = data_reg;

endmodule

// File: rtl/mem_latency_model.sv
// Fixed-latency memory responder for GPU memory-handshake benches.
// Each channel answers a request LATENCY cycles after acceptance with a
// one-cycle ready pulse. The storage array is shared and is never cleared by reset.
// Ports:
//   clk, reset                    clock, asynchronous active-low reset
//   read_valid/read_address       per-channel read requests
//   read_ready/read_data          per-channel read completion pulse and word
//   write_valid/write_address/write_data per-channel write requests
//   write_ready                   per-channel write completion pulse
//   init_en/init_addr/init_data   bench preload port, lowest write priority
module mem_latency_model
    import mem_model_pkg::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 16,
    parameter int CHANNELS  = 1,
    parameter int LATENCY   = 2
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [CHANNELS-1:0]                 read_valid,
    input  logic [CHANNELS-1:0][ADDR_BITS-1:0]  read_address,
    output logic [CHANNELS-1:0]                 read_ready,
    output logic [CHANNELS-1:0][DATA_BITS-1:0]  read_data,
    input  logic [CHANNELS-1:0]                 write_valid,
    input  logic [CHANNELS-1:0][ADDR_BITS-1:0]  write_address,
    input  logic [CHANNELS-1:0][DATA_BITS-1:0]  write_data,
    output logic [CHANNELS-1:0]                 write_ready,
    input  logic                                init_en,
    input  logic [ADDR_BITS-1:0]                init_addr,
    input  logic [DATA_BITS-1:0]                init_data
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    logic [DATA_BITS-1:0] mem [0:DEPTH-1];

    logic [CHANNELS-1:0][ADDR_BITS-1:0] ch_addr;
    logic [CHANNELS-1:0][DATA_BITS-1:0] ch_rdata;
    logic [CHANNELS-1:0]                commit;
    logic [CHANNELS-1:0][ADDR_BITS-1:0] commit_addr;
    logic [CHANNELS-1:0][DATA_BITS-1:0] commit_data;

    // Later non-blocking assignments win, so ordering sets the priority:
    // preload first, then channels in ascending index (highest index wins).
    always_ff @(posedge clk) begin
        if (init_en) begin
            mem[init_addr] <= init_data;
        end
        for (int i = 0; i < CHANNELS; i++) begin
            if (commit[i]) begin
                mem[commit_addr[i]] <= commit_data[i];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
            // The channel registers this word when it enters RESP.
            assign ch_rdata[gi] = mem[ch_addr[gi]];

            mem_model_channel #(
                .ADDR_BITS (ADDR_BITS),
                .DATA_BITS (DATA_BITS),
                .LATENCY   (LATENCY)
            ) u_channel (
                .clk           (clk),
                .reset         (reset),
                .read_valid    (read_valid[gi]),
                .read_address  (read_address[gi]),
                .read_ready    (read_ready[gi]),
                .read_data     (read_data[gi]),
                .write_valid   (write_valid[gi]),
                .write_address (write_address[gi]),
                .write_data    (write_data[gi]),
                .write_ready   (write_ready[gi]),
                .mem_addr      (ch_addr[gi]),
                .mem_rdata     (ch_rdata[gi]),
                .commit        (commit[gi]),
                .commit_addr   (commit_addr[gi]),
                .commit_data   (commit_data[gi])
            );
        end
    endgenerate

endmodule
